cosim_bootram: RTL and testbench
================================

# cosim_bootram

Parametrised, reloadable boot memory for Dromajo co-simulation. After reset it zero-fills itself, accepts a stream of checkpoint words over a valid/ready load port, then serves fully pipelined reads to the core's boot path with configurable latency.

- Out-of-range reads return zero and are flagged, so no X reaches speculative fetch.
- It replaces a fixed 64-bit, 4096-word, single-cycle, file-loaded ROM.
- It sits on the fetch/boot path next to the debug ROM.

## Interface
Parameters:
- DataWidth, 64: word width in bits; power of two, ≥ 8.
- AddrWidth, 64: byte-address width of `addr_i`.
- Depth, 4096: number of words; power of two, ≥ 2.
- ReadLatency, 1: cycles from request accept to `rvalid_o`; legal 1..4.
- IdxWidth, derived: $clog2(Depth), the word-index width.
- OffWidth, derived: $clog2(DataWidth/8), the byte-offset width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- reload_i  in  1  restart the clear+load sequence; sampled only in READY.
- ld_valid_i  in  1  load beat valid.
- ld_ready_o  out  1  load beat accepted when high together with `ld_valid_i`.
- ld_idx_i  in  AddrWidth  word index of the load beat.
- ld_data_i  in  DataWidth  load beat data.
- ld_last_i  in  1  final beat of the checkpoint.
- ld_err_o  out  1  sticky flag: a load beat had an out-of-range index.
- boot_ready_o  out  1  high in READY.
- req_i  in  1  read request.
- gnt_o  out  1  read grant; equals `boot_ready_o`.
- addr_i  in  AddrWidth  byte address.
- rvalid_o  out  1  read data valid.
- rdata_o  out  DataWidth  read data; zero whenever `rvalid_o` is low.
- rerr_o  out  1  qualifies `rvalid_o`; high means the address was out of range.

## Operation
- State machine: CLEAR → LOAD → READY → (reload_i) → CLEAR.
- Reset (`rst_ni`=0 at a clock edge) forces:
  - state = CLEAR, clear counter = 0;
  - read pipeline emptied;
  - all outputs 0, including `ld_err_o`.
- Memory array contents are not reset directly; CLEAR zeroes them.
- CLEAR:
  - writes 0 to mem[counter] each cycle, then increments the counter;
  - after writing word Depth-1, moves to LOAD;
  - lasts exactly Depth cycles;
  - `ld_ready_o`=0, `gnt_o`=0.
- LOAD:
  - `ld_ready_o`=1;
  - an accepted beat writes mem[ld_idx_i] = ld_data_i when ld_idx_i < Depth;
  - otherwise the beat is dropped and `ld_err_o` is set (sticky until reset or reload);
  - an accepted beat with `ld_last_i`=1 moves to READY, whether or not its index was in range;
  - later beats to the same index overwrite earlier ones.
- READY:
  - `gnt_o`=1; every `req_i` is accepted, one per cycle;
  - index = addr_i[OffWidth +: IdxWidth];
  - out of range = any addr_i bit at or above OffWidth+IdxWidth is set → response `rdata_o`=0, `rerr_o`=1;
  - byte-offset bits are ignored; no alignment check.
- Reload:
  - `reload_i`=1 in READY moves to CLEAR on the next edge, resets the counter and clears `ld_err_o`;
  - a read requested in the same cycle as reload is still accepted;
  - reads already accepted complete normally with pre-clear data, because data is captured at accept.
- `reload_i` is ignored in CLEAR and LOAD.

## Timing
- Read:
  - request accepted at edge E0 (`req_i`&`gnt_o`);
  - the array is read at E0;
  - `rvalid_o`, `rdata_o` and `rerr_o` are valid from edge E0+(ReadLatency-1) for one cycle; with ReadLatency=1 that is the cycle right after acceptance.
  - Back-to-back requests give back-to-back responses in order.
  - No backpressure on responses.
- Load beat: the write commits at the accept edge. A read of that index can only happen after READY, so no bypass is needed.
- `boot_ready_o` rises on the edge that accepts the last beat. Earliest first grant: Depth+1 cycles after reset release, with a single-beat load presented immediately.
- Reset mid-read: pending responses are discarded and `rvalid_o` is 0 on the cycle after the reset edge.
- Reset mid-load: the partial load is discarded and the sequence restarts at CLEAR.
- The clear counter is IdxWidth+1 bits and must not wrap into a second pass.

## Test plan
- Reset, Depth=16, one beat (idx 3, data 0xDEAD_BEEF, last) offered at cycle 0 → `ld_ready_o` first high at cycle 16; `boot_ready_o`=1 at cycle 17; read of addr 0x18 returns 0xDEAD_BEEF with `rerr_o`=0; read of addr 0x20 returns 0.
- ReadLatency=3, requests to addr 0x0, 0x8, 0x10 on consecutive cycles → three consecutive `rvalid_o` pulses starting 3 cycles after the first accept, data in request order.
- Read of addr 0x1_0000_0000 (Depth=4096, DataWidth=64) → `rvalid_o`=1, `rerr_o`=1, `rdata_o`=0.
- Load beat with idx 5000 (Depth=4096), followed by a valid last beat → `ld_err_o`=1 and stays high; memory otherwise correct; `boot_ready_o`=1.
- After a load of idx 2 = 0x55, assert `reload_i` together with a read of addr 0x10:
  - the read returns 0x55;
  - `gnt_o` drops next cycle;
  - after the new load (no write to idx 2), idx 2 reads 0.
- Pull `rst_ni` low for 1 cycle mid-LOAD with a read pipeline full (ReadLatency=2) → all outputs 0 next cycle; CLEAR restarts and takes a full Depth cycles.

Source files
------------

// File: rtl/cosim_bootram.sv
// Reloadable boot memory for co-simulation: self-clears after reset, takes a
// checkpoint over a valid/ready load port, then serves pipelined boot reads.
module cosim_bootram #(
    parameter int DataWidth   = 64,
    parameter int AddrWidth   = 64,
    parameter int Depth       = 4096,
    parameter int ReadLatency = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 reload_i,
    input  logic                 ld_valid_i,
    output logic                 ld_ready_o,
    input  logic [AddrWidth-1:0] ld_idx_i,
    input  logic [DataWidth-1:0] ld_data_i,
    input  logic                 ld_last_i,
    output logic                 ld_err_o,
    output logic                 boot_ready_o,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic [AddrWidth-1:0] addr_i,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 rerr_o
);

    localparam int IdxWidth = $clog2(Depth);
    localparam int OffWidth = $clog2(DataWidth / 8);
    localparam int CntWidth = IdxWidth + 1;
    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(Depth - 1);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_LOAD,
        ST_READY
    } state_e;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  ld_err_q, ld_err_d;

    logic [DataWidth-1:0]  mem_q [Depth];
    logic                  wr_en;
    logic [IdxWidth-1:0]   wr_idx;
    logic [DataWidth-1:0]  wr_data;

    logic                  ld_ready;
    logic                  boot_ready;
    logic                  ld_oor;

    logic [AddrWidth-1:0]  addr_word;
    logic [IdxWidth-1:0]   rd_idx;
    logic                  rd_oor;
    logic                  rd_acc;

    logic                  vld_q  [ReadLatency];
    logic                  vld_d  [ReadLatency];
    logic                  err_q  [ReadLatency];
    logic                  err_d  [ReadLatency];
    logic [DataWidth-1:0]  data_q [ReadLatency];
    logic [DataWidth-1:0]  data_d [ReadLatency];

    assign ld_oor = |(ld_idx_i >> IdxWidth);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ld_err_d   = ld_err_q;
        wr_en      = 1'b0;
        wr_idx     = cnt_q[IdxWidth-1:0];
        wr_data    = '0;
        ld_ready   = 1'b0;
        boot_ready = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                wr_en = 1'b1;
                // Leave after the last word so the counter never starts a second pass.
                if (cnt_q == LastCnt) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid_i) begin
                    if (ld_oor) begin
                        ld_err_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_idx  = ld_idx_i[IdxWidth-1:0];
                        wr_data = ld_data_i;
                    end
                    if (ld_last_i) begin
                        state_d = ST_READY;
                    end
                end
            end
            ST_READY: begin
                boot_ready = 1'b1;
                if (reload_i) begin
                    state_d  = ST_CLEAR;
                    cnt_d    = '0;
                    ld_err_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_CLEAR;
            cnt_q    <= '0;
            ld_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ld_err_q <= ld_err_d;
        end
    end

    // The array itself has no reset; CLEAR is what makes its contents defined.
    always_ff @(posedge clk_i) begin
        if (rst_ni && wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign addr_word = addr_i >> OffWidth;
    assign rd_idx    = addr_word[IdxWidth-1:0];
    assign rd_oor    = |(addr_word >> IdxWidth);
    assign rd_acc    = req_i & boot_ready;

    // Data is captured at accept, so a reload cannot corrupt reads in flight.
    always_comb begin
        vld_d[0]  = rd_acc;
        err_d[0]  = rd_acc & rd_oor;
        data_d[0] = (rd_acc && !rd_oor) ? mem_q[rd_idx] : '0;
        for (int i = 1; i < ReadLatency; i++) begin
            vld_d[i]  = vld_q[i-1];
            err_d[i]  = err_q[i-1];
            data_d[i] = data_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < ReadLatency; i++) begin
                vld_q[i]  <= 1'b0;
                err_q[i]  <= 1'b0;
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ReadLatency; i++) begin
                vld_q[i]  <= vld_d[i];
                err_q[i]  <= err_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign ld_ready_o   = ld_ready;
    assign ld_err_o     = ld_err_q;
    assign boot_ready_o = boot_ready;
    assign gnt_o        = boot_ready;
    assign rvalid_o     = vld_q[ReadLatency-1];
    assign rerr_o       = err_q[ReadLatency-1];
    assign rdata_o      = data_q[ReadLatency-1];

endmodule

// File: tb/tb_cosim_bootram.sv
// Directed bench for cosim_bootram: two instances (read latency 1 and 3)
// share one stimulus stream; vectors carry hand-computed expectations.
module tb_cosim_bootram;

    localparam int DW    = 64;
    localparam int AW    = 64;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_ni;
    logic          reload;
    logic          ld_valid;
    logic          ld_last;
    logic          req;
    logic [AW-1:0] ld_idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] ld_data;

    logic          a_ld_ready, a_ld_err, a_boot_ready, a_gnt, a_rvalid, a_rerr;
    logic [DW-1:0] a_rdata;
    logic          b_ld_ready, b_ld_err, b_boot_ready, b_gnt, b_rvalid, b_rerr;
    logic [DW-1:0] b_rdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          err;
    } rd_vec_t;

    rd_vec_t vecs[10];

    cosim_bootram #(.DataWidth(DW), .AddrWidth(AW), .Depth(DEPTH), .ReadLatency(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .reload_i(reload),
        .ld_valid_i(ld_valid), .ld_ready_o(a_ld_ready), .ld_idx_i(ld_idx),
        .ld_data_i(ld_data), .ld_last_i(ld_last), .ld_err_o(a_ld_err),
        .boot_ready_o(a_boot_ready), .req_i(req), .gnt_o(a_gnt), .addr_i(addr),
        .rvalid_o(a_rvalid), .rdata_o(a_rdata), .rerr_o(a_rerr)
    );

    cosim_bootram #(.DataWidth(DW), .AddrWidth(AW), .Depth(DEPTH), .ReadLatency(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .reload_i(reload),
        .ld_valid_i(ld_valid), .ld_ready_o(b_ld_ready), .ld_idx_i(ld_idx),
        .ld_data_i(ld_data), .ld_last_i(ld_last), .ld_err_o(b_ld_err),
        .boot_ready_o(b_boot_ready), .req_i(req), .gnt_o(b_gnt), .addr_i(addr),
        .rvalid_o(b_rvalid), .rdata_o(b_rdata), .rerr_o(b_rerr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, ".a_ld_ready"}, 64'(a_ld_ready), 64'd0);
        checkOutput({name, ".a_ld_err"}, 64'(a_ld_err), 64'd0);
        checkOutput({name, ".a_boot_ready"}, 64'(a_boot_ready), 64'd0);
        checkOutput({name, ".a_gnt"}, 64'(a_gnt), 64'd0);
        checkOutput({name, ".a_rvalid"}, 64'(a_rvalid), 64'd0);
        checkOutput({name, ".a_rdata"}, a_rdata, 64'd0);
        checkOutput({name, ".a_rerr"}, 64'(a_rerr), 64'd0);
        checkOutput({name, ".b_rvalid"}, 64'(b_rvalid), 64'd0);
        checkOutput({name, ".b_rdata"}, b_rdata, 64'd0);
        checkOutput({name, ".b_ld_err"}, 64'(b_ld_err), 64'd0);
    endtask

    // Called in a CLEAR cycle whose index is 'start'; returns in the first LOAD cycle.
    task automatic waitLoad(input string name, input int start);
        int n;
        n = start;
        while (!a_ld_ready && n < 100) begin
            step();
            n++;
        end
        checkOutput(name, 64'(n), 64'(DEPTH));
        checkOutput({name, ".b_ld_ready"}, 64'(b_ld_ready), 64'd1);
    endtask

    task automatic loadBeat(input logic [AW-1:0] idx, input logic [DW-1:0] data, input logic last);
        checkOutput("ld_ready_in_load", 64'(a_ld_ready), 64'd1);
        ld_valid = 1'b1;
        ld_idx   = idx;
        ld_data  = data;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic applyStimulus(input logic [AW-1:0] a);
        req  = 1'b1;
        addr = a;
        step();
        req  = 1'b0;
        addr = '0;
    endtask

    task automatic readCheck(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp_data, input logic exp_err);
        applyStimulus(a);
        checkOutput({name, ".a_rvalid"}, 64'(a_rvalid), 64'd1);
        checkOutput({name, ".a_rdata"}, a_rdata, exp_data);
        checkOutput({name, ".a_rerr"}, 64'(a_rerr), 64'(exp_err));
        checkOutput({name, ".b_rvalid_early"}, 64'(b_rvalid), 64'd0);
        step();
        step();
        checkOutput({name, ".b_rvalid"}, 64'(b_rvalid), 64'd1);
        checkOutput({name, ".b_rdata"}, b_rdata, exp_data);
        checkOutput({name, ".b_rerr"}, 64'(b_rerr), 64'(exp_err));
        checkOutput({name, ".a_rdata_idle"}, a_rdata, 64'd0);
        step();
    endtask

    initial begin
        logic [DW-1:0] bb_data [3];
        logic          exp_v;
        logic [DW-1:0] exp_d;

        vecs[0] = '{64'h0,           64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[1] = '{64'h8,           64'hFFFF_0000_FFFF_0000, 1'b0};
        vecs[2] = '{64'h10,          64'h55,                  1'b0};
        vecs[3] = '{64'h13,          64'h55,                  1'b0};
        vecs[4] = '{64'h78,          64'hCAFE_F00D_0000_0015, 1'b0};
        vecs[5] = '{64'h7F,          64'hCAFE_F00D_0000_0015, 1'b0};
        vecs[6] = '{64'h80,          64'h0,                   1'b1};
        vecs[7] = '{64'h1_0000_0000, 64'h0,                   1'b1};
        vecs[8] = '{64'h18,          64'h0,                   1'b0};
        vecs[9] = '{64'h40,          64'h0,                   1'b0};
        bb_data[0] = 64'h0123_4567_89AB_CDEF;
        bb_data[1] = 64'hFFFF_0000_FFFF_0000;
        bb_data[2] = 64'h55;

        rst_ni = 1'b0; reload = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        req = 1'b0; ld_idx = '0; addr = '0; ld_data = '0;
        step();
        step();
        checkAllZero("reset");

        // Single beat offered from the first cycle after reset release.
        rst_ni   = 1'b1;
        ld_valid = 1'b1;
        ld_idx   = 64'd3;
        ld_data  = 64'hDEAD_BEEF;
        ld_last  = 1'b1;
        waitLoad("first_ld_ready_cycle", 0);
        checkOutput("boot_ready_in_load", 64'(a_boot_ready), 64'd0);
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        checkOutput("boot_ready_cycle17", 64'(a_boot_ready), 64'd1);
        checkOutput("gnt_cycle17", 64'(a_gnt), 64'd1);
        checkOutput("ld_ready_after_last", 64'(a_ld_ready), 64'd0);
        readCheck("rd_idx3", 64'h18, 64'hDEAD_BEEF, 1'b0);
        readCheck("rd_cleared_idx4", 64'h20, 64'h0, 1'b0);

        // Reload, then a multi-beat checkpoint with an overwrite and a bad index.
        reload = 1'b1;
        step();
        reload = 1'b0;
        checkOutput("gnt_after_reload", 64'(a_gnt), 64'd0);
        waitLoad("reload_clear_len", 0);
        loadBeat(64'd0, 64'h0123_4567_89AB_CDEF, 1'b0);
        loadBeat(64'd1, 64'h1111, 1'b0);
        step();
        loadBeat(64'd5000, 64'hBAD, 1'b0);
        checkOutput("ld_err_set", 64'(a_ld_err), 64'd1);
        loadBeat(64'd2, 64'h55, 1'b0);
        loadBeat(64'd1, 64'hFFFF_0000_FFFF_0000, 1'b0);
        loadBeat(64'd15, 64'hCAFE_F00D_0000_0015, 1'b1);
        checkOutput("boot_ready_after_load", 64'(a_boot_ready), 64'd1);
        checkOutput("ld_err_sticky", 64'(a_ld_err), 64'd1);

        for (int i = 0; i < 10; i++) begin
            readCheck($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].err);
        end
        checkOutput("ld_err_still_set", 64'(b_ld_err), 64'd1);

        // Back-to-back reads: in-order responses at latency 1 and 3.
        for (int t = 0; t < 7; t++) begin
            if (t < 3) begin
                req  = 1'b1;
                addr = AW'(t * 8);
            end else begin
                req  = 1'b0;
                addr = '0;
            end
            exp_v = (t >= 1 && t <= 3);
            exp_d = exp_v ? bb_data[t-1] : '0;
            checkOutput($sformatf("b2b_t%0d.a_rvalid", t), 64'(a_rvalid), 64'(exp_v));
            checkOutput($sformatf("b2b_t%0d.a_rdata", t), a_rdata, exp_d);
            exp_v = (t >= 3 && t <= 5);
            exp_d = exp_v ? bb_data[t-3] : '0;
            checkOutput($sformatf("b2b_t%0d.b_rvalid", t), 64'(b_rvalid), 64'(exp_v));
            checkOutput($sformatf("b2b_t%0d.b_rdata", t), b_rdata, exp_d);
            step();
        end

        // Reload together with a read: the read still returns pre-clear data.
        req    = 1'b1;
        addr   = 64'h10;
        reload = 1'b1;
        step();
        req    = 1'b0;
        reload = 1'b0;
        addr   = '0;
        checkOutput("reload_rd.gnt", 64'(a_gnt), 64'd0);
        checkOutput("reload_rd.ld_err_cleared", 64'(a_ld_err), 64'd0);
        checkOutput("reload_rd.a_rvalid", 64'(a_rvalid), 64'd1);
        checkOutput("reload_rd.a_rdata", a_rdata, 64'h55);
        step();
        step();
        checkOutput("reload_rd.b_rvalid", 64'(b_rvalid), 64'd1);
        checkOutput("reload_rd.b_rdata", b_rdata, 64'h55);
        waitLoad("reload2_clear_len", 2);
        loadBeat(64'd7, 64'h77, 1'b1);
        readCheck("rd_idx2_after_reload", 64'h10, 64'h0, 1'b0);
        readCheck("rd_idx7", 64'h38, 64'h77, 1'b0);

        // Reset with the read pipelines full.
        req  = 1'b1;
        addr = 64'h38;
        step();
        step();
        step();
        req    = 1'b0;
        addr   = '0;
        rst_ni = 1'b0;
        step();
        checkAllZero("reset_mid_read");
        rst_ni = 1'b1;
        waitLoad("post_reset_clear_len", 0);

        // Reset in the middle of a load.
        loadBeat(64'd5000, 64'h0, 1'b0);
        checkOutput("ld_err_before_reset", 64'(a_ld_err), 64'd1);
        loadBeat(64'd4, 64'h44, 1'b0);
        rst_ni = 1'b0;
        step();
        checkAllZero("reset_mid_load");
        rst_ni = 1'b1;
        waitLoad("mid_load_reset_clear_len", 0);
        loadBeat(64'd9, 64'h99, 1'b1);
        readCheck("rd_discarded_idx4", 64'h20, 64'h0, 1'b0);
        readCheck("rd_idx9", 64'h48, 64'h99, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
